synd_accum_serial: RTL and testbench

SYND_ACCUM_SERIAL -- requirements
Module: synd_accum_serial

---
 rtl/synd_accum_serial.sv | 146 ++++++++++++++
 tb/tb_synd_accum_serial.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/synd_accum_serial.sv
// synd_accum_serial
//   Bit-serial BCH syndrome accumulator over GF(2^10), primitive polynomial
//   x^10 + x^3 + 1. A codeword of CODE_LEN bits arrives highest-degree
//   coefficient first. S1, S3 and S5 are evaluated by Horner's rule, so each
//   accepted bit costs one cycle.
//
// Ports
//   clk            system clock, rising edge
//   in_ctr_rst_n   asynchronous active-low reset
//   in_ctr_start   start (or restart) a codeword; clears syndromes and counter
//   in_bit_valid   in_bit carries a codeword bit this cycle
//   in_bit         received codeword bit r(CODE_LEN-1) first
//   out_ready      high while bits are being accepted
//   out_synd_valid one-cycle pulse when the syndromes are final
//   out_synd1/3/5  registered syndromes r(alpha), r(alpha^3), r(alpha^5)
//   out_err_detect any syndrome bit set, qualified by out_synd_valid
module synd_accum_serial #(
  parameter int CODE_LEN = 1023
) (
  input  logic       clk,
  input  logic       in_ctr_rst_n,
  input  logic       in_ctr_start,
  input  logic       in_bit_valid,
  input  logic       in_bit,
  output logic       out_ready,
  output logic       out_synd_valid,
  output logic [9:0] out_synd1,
  output logic [9:0] out_synd3,
  output logic [9:0] out_synd5,
  output logic       out_err_detect
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [9:0] LAST_IDX = 10'(CODE_LEN - 1);

  state_t     state;
  state_t     state_next;
  logic [9:0] count;
  logic [9:0] s1;
  logic [9:0] s3;
  logic [9:0] s5;
  logic       clear_en;
  logic       accept_en;
  logic       last_bit;

  // Multiply by alpha: shift up one degree and fold alpha^10 back in as
  // alpha^3 + 1. Chaining this constant function gives the alpha^3 and alpha^5
  // multipliers as pure XOR networks.
  function automatic logic [9:0] mul_a(input logic [9:0] x);
    logic [9:0] y;
    y    = {x[8:0], 1'b0};
    y[0] = y[0] ^ x[9];
    y[3] = y[3] ^ x[9];
    return y;
  endfunction

  function automatic logic [9:0] mul_a3(input logic [9:0] x);
    return mul_a(mul_a(mul_a(x)));
  endfunction

  function automatic logic [9:0] mul_a5(input logic [9:0] x);
    return mul_a(mul_a(mul_a3(x)));
  endfunction

  assign last_bit = (count == LAST_IDX);

  // State register
  always_ff @(posedge clk or negedge in_ctr_rst_n) begin
    if (!in_ctr_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and datapath controls. A start in any state clears the block;
  // in ACCUM it also discards the bit presented in the same cycle.
  always_comb begin
    state_next = state;
    clear_en   = 1'b0;
    accept_en  = 1'b0;
    case (state)
      IDLE: begin
        if (in_ctr_start) begin
          state_next = ACCUM;
          clear_en   = 1'b1;
        end
      end
      ACCUM: begin
        if (in_ctr_start) begin
          clear_en = 1'b1;
        end else if (in_bit_valid) begin
          accept_en = 1'b1;
          if (last_bit) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (in_ctr_start) begin
          state_next = ACCUM;
          clear_en   = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Horner accumulation and bit counter. The syndromes are left untouched
  // outside ACCUM so the final values stay visible until the next start.
  always_ff @(posedge clk or negedge in_ctr_rst_n) begin
    if (!in_ctr_rst_n) begin
      s1    <= 10'h000;
      s3    <= 10'h000;
      s5    <= 10'h000;
      count <= 10'd0;
    end else if (clear_en) begin
      s1    <= 10'h000;
      s3    <= 10'h000;
      s5    <= 10'h000;
      count <= 10'd0;
    end else if (accept_en) begin
      s1    <= mul_a(s1)  ^ {9'b0, in_bit};
      s3    <= mul_a3(s3) ^ {9'b0, in_bit};
      s5    <= mul_a5(s5) ^ {9'b0, in_bit};
      count <= last_bit ? 10'd0 : count + 10'd1;
    end
  end

  assign out_ready      = (state == ACCUM);
  assign out_synd_valid = (state == DONE);
  assign out_err_detect = (state == DONE) && (|{s1, s3, s5});
  assign out_synd1      = s1;
  assign out_synd3      = s3;
  assign out_synd5      = s5;

endmodule

// File: tb/tb_synd_accum_serial.sv
// tb_synd_accum_serial
//   Self-checking bench for synd_accum_serial. A behavioural model keeps the
//   list of accepted one-bits of the current block and evaluates each
//   syndrome directly as a sum of powers of alpha; a monitor compares every
//   output against it on each falling edge. Directed blocks additionally check
//   hand-computed syndrome values at the result pulse.
module tb_synd_accum_serial;

  localparam int N = 1023;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       bit_valid;
  logic       bit_in;
  logic       ready;
  logic       synd_valid;
  logic [9:0] synd1;
  logic [9:0] synd3;
  logic [9:0] synd5;
  logic       err_detect;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  bit mon_en = 1'b0;

  logic [9:0] exp_t [0:N-1];

  // Model state: 0 idle, 1 collecting, 2 result cycle
  int m_state = 0;
  int m_n = 0;
  int m_ones[$];

  synd_accum_serial #(.CODE_LEN(N)) dut (
    .clk            (clk),
    .in_ctr_rst_n   (rst_n),
    .in_ctr_start   (start),
    .in_bit_valid   (bit_valid),
    .in_bit         (bit_in),
    .out_ready      (ready),
    .out_synd_valid (synd_valid),
    .out_synd1      (synd1),
    .out_synd3      (synd3),
    .out_synd5      (synd5),
    .out_err_detect (err_detect)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Generic shift-and-add GF(2^10) product, reduced by x^10 + x^3 + 1
  function automatic logic [9:0] gf_mul(input logic [9:0] a, input logic [9:0] b);
    logic [18:0] p;
    p = '0;
    for (int i = 0; i < 10; i++) if (b[i]) p = p ^ (19'(a) << i);
    for (int k = 18; k >= 10; k--) if (p[k]) p = p ^ (19'h409 << (k - 10));
    return p[9:0];
  endfunction

  // Syndrome of the bits accepted so far: the bit accepted at index i has
  // degree m_n-1-i, contributing alpha^(j*degree).
  function automatic logic [9:0] model_synd(input int j);
    logic [9:0] s;
    s = '0;
    foreach (m_ones[k]) s = s ^ exp_t[(j * (m_n - 1 - m_ones[k])) % N];
    return s;
  endfunction

  // Behavioural model of block acceptance
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0;
      m_n = 0;
      m_ones.delete();
    end else begin
      case (m_state)
        0: if (start) begin m_state = 1; m_n = 0; m_ones.delete(); end
        1: begin
          if (start) begin
            m_n = 0;
            m_ones.delete();
          end else if (bit_valid) begin
            if (bit_in) m_ones.push_back(m_n);
            m_n++;
            if (m_n == N) m_state = 2;
          end
        end
        default: begin
          if (start) begin m_state = 1; m_n = 0; m_ones.delete(); end
          else m_state = 0;
        end
      endcase
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (mon_en) begin
      logic [9:0] e1, e3, e5;
      e1 = model_synd(1);
      e3 = model_synd(3);
      e5 = model_synd(5);
      checkOutput("mon_ready", ready, m_state == 1);
      checkOutput("mon_synd_valid", synd_valid, m_state == 2);
      checkOutput("mon_synd1", synd1, e1);
      checkOutput("mon_synd3", synd3, e3);
      checkOutput("mon_synd5", synd5, e5);
      checkOutput("mon_err_detect", err_detect, (m_state == 2) && ((e1 | e3 | e5) != 0));
      if (synd_valid === 1'b1) pulses++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one codeword bit, optionally preceded by random idle cycles
  task automatic applyStimulus(input logic b, input bit gaps);
    if (gaps) begin
      while ($urandom_range(0, 9) < 3) begin
        bit_valid = 1'b0;
        bit_in = 1'($urandom_range(0, 1));
        step();
      end
    end
    bit_valid = 1'b1;
    bit_in = b;
    step();
    bit_valid = 1'b0;
    bit_in = 1'b0;
  endtask

  task automatic startPulse(input logic with_bit);
    start = 1'b1;
    bit_valid = with_bit;
    bit_in = with_bit;
    step();
    start = 1'b0;
    bit_valid = 1'b0;
    bit_in = 1'b0;
  endtask

  // One full codeword with a one optionally at the top and/or bottom degree;
  // checks the pulse arrives in the cycle right after the last accepted bit.
  task automatic runBlock(input string name, input bit one_first, input bit one_last,
                          input bit gaps, input bit do_start, input bit chain,
                          input logic [9:0] e1, input logic [9:0] e3, input logic [9:0] e5);
    if (do_start) startPulse(1'b1);
    for (int i = 0; i < N; i++) begin
      applyStimulus((i == 0 && one_first) || (i == N - 1 && one_last), gaps);
    end
    if (chain) start = 1'b1;
    @(negedge clk);
    checkOutput({name, "_pulse"}, synd_valid, 1'b1);
    checkOutput({name, "_s1"}, synd1, e1);
    checkOutput({name, "_s3"}, synd3, e3);
    checkOutput({name, "_s5"}, synd5, e5);
    checkOutput({name, "_err"}, err_detect, (e1 | e3 | e5) != 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput({name, "_pulse_end"}, synd_valid, 1'b0);
    checkOutput({name, "_err_end"}, err_detect, 1'b0);
    if (chain) begin
      checkOutput({name, "_chain_ready"}, ready, 1'b1);
      checkOutput({name, "_chain_clear"}, synd1, 10'h000);
    end else begin
      checkOutput({name, "_idle_ready"}, ready, 1'b0);
      checkOutput({name, "_hold_s1"}, synd1, e1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pulses_before;
    exp_t[0] = 10'h001;
    for (int i = 1; i < N; i++) exp_t[i] = gf_mul(exp_t[i-1], 10'h002);
    checkOutput("model_alpha10", exp_t[10], 10'h009);
    checkOutput("model_alpha1022", exp_t[1022], 10'h204);
    checkOutput("model_wrap", gf_mul(exp_t[1022], 10'h002), 10'h001);

    rst_n = 1'b0;
    start = 1'b0;
    bit_valid = 1'b0;
    bit_in = 1'b0;
    mon_en = 1'b1;
    repeat (3) step();
    checkOutput("rst_ready", ready, 1'b0);
    checkOutput("rst_valid", synd_valid, 1'b0);
    checkOutput("rst_s1", synd1, 10'h000);
    checkOutput("rst_err", err_detect, 1'b0);
    rst_n = 1'b1;
    repeat (2) step();

    $display("[TB] all-zero codeword");
    runBlock("zeros", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h000, 10'h000, 10'h000);
    $display("[TB] r0 = 1");
    runBlock("r0", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'h001, 10'h001, 10'h001);
    $display("[TB] r1022 = 1, restart during result cycle");
    runBlock("r1022", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 10'h204, 10'h081, 10'h122);
    $display("[TB] r1022 = 1 with valid gaps");
    runBlock("gapped", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'h204, 10'h081, 10'h122);
    repeat (4) step();
    checkOutput("idle_hold_s3", synd3, 10'h081);

    $display("[TB] reset mid-block");
    startPulse(1'b0);
    for (int i = 0; i < 500; i++) applyStimulus(i % 7 == 0, 1'b0);
    pulses_before = pulses;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_ready", ready, 1'b0);
    checkOutput("midrst_s1", synd1, 10'h000);
    checkOutput("midrst_s5", synd5, 10'h000);
    step();
    step();
    rst_n = 1'b1;
    bit_valid = 1'b1;
    bit_in = 1'b1;
    repeat (6) step();
    bit_valid = 1'b0;
    bit_in = 1'b0;
    checkOutput("midrst_idle_ready", ready, 1'b0);
    checkOutput("midrst_idle_s1", synd1, 10'h000);
    checkOutput("midrst_no_pulse", pulses, pulses_before);
    runBlock("after_rst", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'h001, 10'h001, 10'h001);
    checkOutput("after_rst_pulses", pulses, pulses_before + 1);

    $display("[TB] restart during accumulation");
    startPulse(1'b0);
    for (int i = 0; i < 200; i++) applyStimulus(i % 3 == 0, 1'b0);
    startPulse(1'b1);
    checkOutput("abort_ready", ready, 1'b1);
    checkOutput("abort_s1", synd1, 10'h000);
    runBlock("abort", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h001, 10'h001, 10'h001);

    repeat (3) step();
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
